// File: rtl/video_stream_packer.sv
// ============================================================================
// video_stream_packer: VS/DE pixel bus -> user/valid/last/ready stream with FIFO.
// Optional line-length check: VIDEO_STREAM_PACKER_LINE_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module video_stream_packer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 1920
) (
    input  logic              I_pixel_clk,
    input  logic              I_rst,
    input  logic              I_video_in_vs,
    input  logic              I_video_in_de,
    input  logic [DATA_W-1:0] I_video_in_data,
    output logic              O_video_out_user,
    output logic              O_video_out_valid,
    output logic              O_video_out_last,
    input  logic              I_video_out_ready,
    output logic [DATA_W-1:0] O_video_out_data,
    output logic              O_overflow,
    output logic              O_line_err,
    output logic [15:0]       O_frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 2;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_ACTIVE < 1) begin : g_bad_params
        $error("video_stream_packer: illegal FIFO_DEPTH or H_ACTIVE");
    end

    typedef enum logic [0:0] {
        WAIT_VS = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic              vs_prev;
    logic              vs_rise;
    logic              capture;
    logic              run_start;
    logic              pix_user;
    logic              arm;
    logic              held_valid;
    logic              held_user;
    logic [DATA_W-1:0] held_data;

    assign vs_rise = I_video_in_vs & ~vs_prev;

    always_ff @(posedge I_pixel_clk) begin
        if (I_rst) begin
            state <= WAIT_VS;
        end else begin
            state <= state_next;
        end
    end

    // A VS edge both leaves WAIT_VS and lets a coincident DE pixel in.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            WAIT_VS: begin
                capture = I_video_in_de & vs_rise;
                if (vs_rise) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                capture = I_video_in_de;
            end
            default: begin
                state_next = WAIT_VS;
            end
        endcase
    end

    // A run starts whenever nothing is held from the previous cycle.
    assign run_start = capture & ~held_valid;
    assign pix_user  = run_start & (arm | vs_rise);

    always_ff @(posedge I_pixel_clk) begin
        if (I_rst) begin
            vs_prev    <= 1'b0;
            arm        <= 1'b0;
            held_valid <= 1'b0;
            held_user  <= 1'b0;
            held_data  <= '0;
        end else begin
            vs_prev    <= I_video_in_vs;
            arm        <= run_start ? 1'b0 : (arm | vs_rise);
            held_valid <= capture;
            if (capture) begin
                held_user <= pix_user;
                held_data <= I_video_in_data;
            end
        end
    end

    logic          wr_req;
    logic          wr_last;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic [EW-1:0] head;

    assign wr_req   = held_valid;
    assign wr_last  = ~capture;
    assign wr_entry = {held_user, wr_last, held_data};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & I_video_out_ready;
    assign wr_en = wr_req & (~full | pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge I_pixel_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge I_pixel_clk) begin
        if (I_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            O_overflow  <= 1'b0;
            O_frame_cnt <= 16'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_req & full & ~pop) begin
                O_overflow <= 1'b1;
            end
            if (pop & head[EW-1]) begin
                O_frame_cnt <= O_frame_cnt + 16'd1;
            end
        end
    end

    assign O_video_out_valid = ~empty;
    assign O_video_out_user  = ~empty & head[EW-1];
    assign O_video_out_last  = ~empty & head[EW-2];
    assign O_video_out_data  = empty ? '0 : head[DATA_W-1:0];

`ifdef VIDEO_STREAM_PACKER_LINE_CHECK_EN
    localparam logic [15:0] H_ACTIVE_W = 16'(H_ACTIVE);

    logic [15:0] line_cnt;
    logic        line_err;

    // A held pixel with no capture this cycle is the line's last beat.
    always_ff @(posedge I_pixel_clk) begin
        if (I_rst) begin
            line_cnt <= 16'd0;
            line_err <= 1'b0;
        end else if (capture) begin
            if (run_start) begin
                line_cnt <= 16'd1;
            end else if (line_cnt != 16'hFFFF) begin
                line_cnt <= line_cnt + 16'd1;
            end
        end else if (wr_req) begin
            if (line_cnt != H_ACTIVE_W) begin
                line_err <= 1'b1;
            end
            line_cnt <= 16'd0;
        end
    end

    assign O_line_err = line_err;
`else
    assign O_line_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_stream_packer.sv
// ============================================================================
// tb_video_stream_packer: directed + random stimulus against a queue model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_video_stream_packer;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int HA    = 4;
`ifdef VIDEO_STREAM_PACKER_LINE_CHECK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vs_in = 1'b0;
    logic          de_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready = 1'b0;
    logic          user, valid, last, overflow, line_err;
    logic [DW-1:0] data_out;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    video_stream_packer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .H_ACTIVE(HA)) dut (
        .I_pixel_clk      (clk),
        .I_rst            (rst),
        .I_video_in_vs    (vs_in),
        .I_video_in_de    (de_in),
        .I_video_in_data  (data_in),
        .O_video_out_user (user),
        .O_video_out_valid(valid),
        .O_video_out_last (last),
        .I_video_out_ready(ready),
        .O_video_out_data (data_out),
        .O_overflow       (overflow),
        .O_line_err       (line_err),
        .O_frame_cnt      (frame_cnt)
    );

    typedef struct packed {
        logic          u;
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    // Reference: output stream as a bounded queue; pixels tagged one cycle late.
    beat_t         q[$];
    beat_t         popped[$];
    bit            m_started, m_arm, m_vs_prev, m_pend_v, m_pend_u, m_ovf, m_lerr;
    logic [DW-1:0] m_pend_d;
    int            m_run_len;
    logic [15:0]   m_fcnt;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit vs, input bit de, input logic [DW-1:0] d,
                              input bit rdy, input bit rs);
        bit    vs_rise, pop_now, was_full, cap, new_run, lst;
        beat_t b;
        if (rs) begin
            q.delete();
            {m_started, m_arm, m_vs_prev, m_pend_v, m_pend_u, m_ovf, m_lerr} = '0;
            m_pend_d  = '0;
            m_run_len = 0;
            m_fcnt    = 16'd0;
            return;
        end
        vs_rise  = vs && !m_vs_prev;
        was_full = (q.size() == DEPTH);
        pop_now  = rdy && (q.size() > 0);
        if (pop_now) begin
            if (q[0].u) m_fcnt = m_fcnt + 16'd1;
            void'(q.pop_front());
        end
        cap = de && (m_started || vs_rise);
        if (m_pend_v) begin
            lst = !cap;
            if (was_full && !pop_now) begin
                m_ovf = 1'b1;
            end else begin
                b.u = m_pend_u; b.l = lst; b.d = m_pend_d;
                q.push_back(b);
            end
            if (lst && LCHK && m_run_len != HA) m_lerr = 1'b1;
        end
        new_run = cap && !m_pend_v;
        if (cap) begin
            m_pend_u  = new_run && (m_arm || vs_rise);
            m_pend_d  = d;
            m_run_len = new_run ? 1 : m_run_len + 1;
        end
        m_arm     = new_run ? 1'b0 : (m_arm || vs_rise);
        m_pend_v  = cap;
        m_started = m_started || vs_rise;
        m_vs_prev = vs;
    endtask

    task automatic check_outputs();
        bit    ev;
        beat_t h;
        ev = (q.size() > 0);
        h  = ev ? q[0] : '0;
        chk("valid", 32'(valid), 32'(ev));
        chk("user", 32'(user), 32'(h.u));
        chk("last", 32'(last), 32'(h.l));
        chk("data", 32'(data_out), 32'(h.d));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("line_err", 32'(line_err), 32'(m_lerr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    endtask

    task automatic step(input bit vs, input bit de, input logic [DW-1:0] d,
                        input bit rdy, input bit rs = 1'b0);
        beat_t b;
        @(negedge clk);
        rst = rs; vs_in = vs; de_in = de; data_in = d; ready = rdy;
        #1;
        if (valid && rdy && !rs) begin
            b.u = user; b.l = last; b.d = data_out;
            popped.push_back(b);
        end
        @(posedge clk);
        model_edge(vs, de, d, rdy, rs);
        #1;
        check_outputs();
    endtask

    function automatic bit pick_ready(input int mode);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return (mode != 0);
    endfunction

    task automatic idle(input int n, input int mode);
        repeat (n) step(1'b0, 1'b0, '0, pick_ready(mode));
    endtask

    task automatic vs_pulse(input int mode);
        step(1'b1, 1'b0, '0, pick_ready(mode));
        step(1'b0, 1'b0, '0, pick_ready(mode));
    endtask

    task automatic line(input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            step((mode == 2) && ($urandom_range(0, 9) == 0), 1'b1, DW'($urandom),
                 pick_ready(mode));
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nl;
        // Reset state
        do_reset();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // DE before any VS edge is ignored
        repeat (4) step(1'b0, 1'b1, DW'($urandom), 1'b1);
        idle(2, 1);
        chk("pre_vs_valid", 32'(valid), 32'd0);

        // Two 4-pixel lines, ready high; check 2-cycle latency explicitly
        popped.delete();
        vs_pulse(1);
        step(1'b0, 1'b1, 24'h000111, 1'b1);
        chk("lat_edge_n", 32'(valid), 32'd0);
        step(1'b0, 1'b1, 24'h000222, 1'b1);
        chk("lat_edge_n1", 32'(valid), 32'd1);
        chk("lat_data", 32'(data_out), 32'h000111);
        line(2, 1);
        idle(2, 1);
        line(4, 1);
        idle(4, 1);
        chk("f1_beats", 32'(popped.size()), 32'd8);
        if (popped.size() >= 8) begin
            chk("f1_user0", 32'(popped[0].u), 32'd1);
            chk("f1_last3", 32'(popped[3].l), 32'd1);
            chk("f1_last7", 32'(popped[7].l), 32'd1);
        end
        chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Back-pressure: 20-pixel line into a 16-deep FIFO
        do_reset();
        popped.delete();
        vs_pulse(0);
        line(20, 0);
        idle(3, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        idle(24, 1);
        chk("ovf_beats", 32'(popped.size()), 32'd16);
        nl = 0;
        foreach (popped[i]) if (popped[i].l) nl++;
        chk("ovf_no_last", 32'(nl), 32'd0);

        // One-pixel run right after VS
        popped.delete();
        vs_pulse(1);
        step(1'b0, 1'b1, 24'hABCDEF, 1'b1);
        idle(4, 1);
        chk("one_px_beats", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) begin
            chk("one_px_user", 32'(popped[0].u), 32'd1);
            chk("one_px_last", 32'(popped[0].l), 32'd1);
        end

        // Short line
        do_reset();
        vs_pulse(1);
        line(3, 1);
        idle(3, 1);
        chk("short_line_err", 32'(line_err), 32'(LCHK));

        // Reset mid-line with 5 beats buffered
        do_reset();
        vs_pulse(0);
        line(6, 0);
        step(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) step(1'b0, 1'b1, DW'($urandom), 1'b1);
        chk("midrst_no_out", 32'(valid), 32'd0);
        popped.delete();
        idle(1, 1);
        vs_pulse(1);
        line(4, 1);
        idle(3, 1);
        chk("midrst_next_beats", 32'(popped.size()), 32'd4);
        if (popped.size() >= 1) chk("midrst_next_user", 32'(popped[0].u), 32'd1);

        // Random frames with random ready and stray VS edges
        for (int f = 0; f < 8; f++) begin
            vs_pulse(2);
            for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
                line(int'($urandom_range(1, 6)), 2);
                idle(int'($urandom_range(1, 3)), 2);
            end
        end
        idle(40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_stream_packer.md
# video_stream_packer

Converts the pixel-rate RGB timing interface (VS / DE / 24-bit data) into the user/valid/last/ready video stream consumed by the HDMI transmitter's stream input. It sits directly upstream of the transmitter on the pixel clock domain. It tags start-of-frame and end-of-line, and absorbs downstream ready back-pressure in a small FIFO. It also reports overflow, line-length errors and a running frame count.

## Interface
- DATA_W, 24, pixel data width.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two and at least 4.
- H_ACTIVE, 1920, expected pixels per DE run; used by the line check.

- I_pixel_clk  in  1  pixel clock; the only clock.
- I_rst  in  1  synchronous, active-high reset.
- I_video_in_vs  in  1  frame sync, active high; its rising edge marks a new frame.
- I_video_in_de  in  1  active-pixel enable.
- I_video_in_data  in  DATA_W  pixel, sampled when DE is high.
- O_video_out_user  out  1  first pixel of a frame.
- O_video_out_valid  out  1  output beat valid.
- O_video_out_last  out  1  last pixel of a line.
- I_video_out_ready  in  1  downstream accept.
- O_video_out_data  out  DATA_W  pixel.
- O_overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- O_line_err  out  1  sticky: a DE run length differed from H_ACTIVE.
- O_frame_cnt  out  16  count of user-tagged beats accepted downstream; wraps.

## Operation
- Two states:
  - WAIT_VS (the reset state): DE and data are ignored; nothing is written to the FIFO.
  - RUN: entered on the first VS rising edge (VS high, previous VS low). The block then stays in RUN until reset.
- SOF arm flag:
  - Set on every VS rising edge.
  - Cleared when the first pixel of the next DE run is captured; that pixel carries user=1.
  - A VS rising edge while DE is high does not tag the current run; the arm applies to the next run.
- Lookahead stage: each DE-high pixel is held for one cycle together with its user bit.
  - If DE is still high in the next cycle, the held pixel is written to the FIFO with last=0.
  - If DE is low in the next cycle, it is written with last=1.
  - A one-pixel run is written with user=1 and last=1 when it carries SOF.
- FIFO: FIFO_DEPTH entries of {user, last, data}, show-ahead.
  - valid = not empty.
  - A pop happens on valid & ready.
  - The output fields are always the head entry; data is 0 when empty.
- Full FIFO:
  - A write attempted while full with no pop in the same cycle is dropped and sets O_overflow.
  - A simultaneous pop and write when full succeeds, and occupancy stays full.
  - Pointers use log2(FIFO_DEPTH)+1 bits, with the wrap bit distinguishing full from empty.
- Line counter:
  - 16 bits, counts the pixels of the current DE run and saturates at 0xFFFF.
  - On the beat written with last=1, if count ≠ H_ACTIVE, O_line_err is set. The counter then clears.
- O_frame_cnt increments by 1 on each popped beat with user=1, wrapping 0xFFFF→0.
- Sticky flags clear only on reset.

## Timing
- Reset, evaluated at the clock edge:
  - FIFO flushed; state WAIT_VS; arm cleared; held pixel discarded; counters cleared.
  - All outputs 0: valid, user, last, data, O_overflow, O_line_err, O_frame_cnt.
  - A reset mid-line or mid-frame drops all buffered pixels; no output until the next VS rising edge.
- Latency: a pixel sampled at edge n is written at edge n+1. With the FIFO empty, O_video_out_valid is high in the cycle following edge n+1, i.e. 2 cycles input-to-output.
- Ready may be held low indefinitely: data and flags stay stable while valid is high and ready is low.
- Throughput: 1 beat/cycle when ready is continuously high, so the FIFO never fills.
- VS rising and a DE-high pixel in the same cycle: that pixel starts a new run and is tagged user.

## Configuration
- VIDEO_STREAM_PACKER_LINE_CHECK_EN:
  - Defined: the line counter and O_line_err logic are compiled in as described.
  - Undefined: no line counter exists; O_line_err is tied to 0. All other behaviour is identical.

## Test plan
- Reset, 4-pixel VS/DE frame with 2 lines of H_ACTIVE=4, ready=1 → 8 beats.
  - Beat 0 has user=1; beats 3 and 7 have last=1.
  - Beat 0 is valid 2 cycles after its input; O_frame_cnt=1.
- DE pixels before the first VS edge after reset → no FIFO writes; valid stays 0.
- ready=0, FIFO_DEPTH=16, one 20-pixel line → the 16 oldest pixels are retained and O_overflow=1. Releasing ready yields exactly 16 beats in order, and last never appears.
- One-pixel DE run right after a VS edge → a single beat with user=1 and last=1.
- H_ACTIVE=4, a 3-pixel line with the macro defined → O_line_err=1 after that line's last beat. With the macro undefined, O_line_err stays 0.
- Reset asserted mid-line with 5 beats buffered → valid=0 on the next cycle and O_frame_cnt=0. The next frame after VS streams normally.
